mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline, between EX and WB.
- Holds one instruction and waits for the data-SRAM response of a load or store issued in EX.
- Extracts and sign/zero-extends load data, and forwards the register-write triple to ID for bypass and hazard checks.
- Passes CSR and exception information to WB, and safely discards an in-flight response when WB flushes the pipeline.

Parameters:
- ES2MS_W, 164, width of es2ms_bus.
- MS2WS_W, 118, width of ms2ws_bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- es2ms_valid  in  1  EX holds a valid instruction for MS.
- ms_allowin  out  1  MS can accept from EX this cycle.
- es2ms_bus  in  164  MSB-first: pc[32], mem_op[5] {ld_b,ld_h,ld_w,ld_bu,ld_hu}, res_from_mem[1], mem_req[1] (SRAM request accepted in EX), csr_re[1], rf_we[1], rf_waddr[5], alu_result[32], csr_num[14], csr_wmask[32], csr_wvalue[32], csr_we[1], ex_int, ex_brk, ex_ine, ex_adef, ex_sys, ertn[6], ex_ale[1].
- data_sram_data_ok  in  1  response strobe for the oldest outstanding request.
- data_sram_rdata  in  32  response data.
- ws_allowin  in  1  WB can accept.
- ms2ws_valid  out  1  MS hands an instruction to WB.
- ms2ws_bus  out  118  MSB-first: pc, csr_num, csr_wmask, csr_wvalue, csr_we, ex_int, ex_brk, ex_ine, ex_adef, ex_sys, ertn, ex_ale.
- ms_rf_zip  out  39  {csr_re, rf_we, rf_waddr, rf_wdata}.
- ms_ld_pending  out  1  valid load still waiting for data; ID must stall on a RAW hit.
- ms_ex  out  1  MS holds a valid exception or ertn; EX must not issue stores.
- wb_ex  in  1  WB exception flush.
- ertn_flush  in  1  WB ertn flush.

Behaviour:
- Reset: ms_valid=0, cancel=0, buf_valid=0, all latched payload=0. Every output derived from these is therefore 0, except ms_allowin=1.
- Valid register:
  - flush = wb_ex|ertn_flush.
  - If flush, ms_valid<=0.
  - Else if ms_allowin, ms_valid<=es2ms_valid.
  - Payload latches on es2ms_valid & ms_allowin.
- ms_ready_go = ~mem_req | buf_valid | (data_sram_data_ok & ~cancel).
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ms_ready_go & ~flush.
- Latency: non-memory op passes in 1 cycle. A memory op stays until its data_ok arrives, whose earliest is the same cycle it enters MS.
- Response buffer:
  - data_ok accepted (cancel=0) while ws_allowin=0 → rdata_buf<=rdata, buf_valid<=1.
  - buf_valid clears when the instruction leaves MS or on flush.
  - Load data comes from buf when buf_valid, else from live rdata.
- Cancel flag:
  - Set on a flush cycle if ms_valid & mem_req & ~buf_valid & ~data_ok.
  - While set, the next data_ok is discarded and clears cancel.
  - Meanwhile a new instruction may enter, but its own data_ok is counted only after cancel clears.
  - Flush in the same cycle as data_ok does not set cancel.
- Load extract: addr[1:0] = alu_result[1:0].
  - ld_b/ld_bu: byte addr[1:0], sign/zero extended to 32.
  - ld_h/ld_hu: half addr[1] ({addr[1],1'b0}), sign/zero extended.
  - ld_w: full word.
- rf_wdata = res_from_mem ? load_data : alu_result.
- ms_rf_zip:
  - csr_re field = csr_re & ms_valid.
  - rf_we field = rf_we & ms_valid & ~any_ex, where any_ex = int|brk|ine|adef|sys|ale.
- ms_ld_pending = ms_valid & res_from_mem & ~ms_ready_go.
- ms_ex = ms_valid & (any_ex | ertn).
- ALE instruction carries mem_req=0 (no request issued) and passes without waiting.
- resetn low mid-wait clears everything including cancel. The SRAM is reset with the core.

Decomposition:
- Shared package: ES2MS_W/MS2WS_W and field offset constants, mem_op bit indices, ecode constants.
- One sub-module: mem_load_align (mem_op, addr[1:0], rdata → 32-bit result), purely combinational.

Test Plan:
- ld_w, mem_req=1, data_ok 3 cycles after entry, rdata=0x8765_4321 → ms2ws_valid high only in data_ok cycle; ms_rf_zip wdata=0x87654321; ms_ld_pending high the prior 3 cycles.
- ld_b addr=2'b11, rdata=0x80xx_xxxx → wdata=0xFFFF_FF80. Same with ld_bu → 0x0000_0080. ld_hu addr=2'b10, rdata=0xBEEF_0000 → 0x0000_BEEF.
- data_ok while ws_allowin=0, rdata=0x1234 → buffered; ws_allowin rises 2 cycles later → ms2ws_valid=1 with wdata=0x1234, with no second data_ok needed.
- Load waiting, wb_ex pulse → ms_valid=0 next cycle. New ld_w enters. First data_ok (rdata=0xDEAD) dropped; second data_ok (0xBEEF) completes the new load with 0xBEEF.
- add with ex_sys=1, rf_we=1 → ms_ex=1, ms_rf_zip rf_we=0, ms2ws_bus ex_sys bit=1, 1-cycle pass.
- resetn low for 1 cycle while waiting with cancel set → all outputs 0, ms_allowin=1. The next load completes on its first data_ok.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the MEM stage of the LoongArch pipeline:
//   bus widths, the field layout of the EX->MS and MS->WS buses (as packed
//   structs, MSB first), mem_op bit indices and exception codes.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int ES2MS_W  = 164;
    localparam int MS2WS_W  = 118;
    localparam int RF_ZIP_W = 39;
    localparam int MEM_OP_W = 5;

    // Bit positions inside mem_op = {ld_b, ld_h, ld_w, ld_bu, ld_hu}
    localparam int LD_B_BIT  = 4;
    localparam int LD_H_BIT  = 3;
    localparam int LD_W_BIT  = 2;
    localparam int LD_BU_BIT = 1;
    localparam int LD_HU_BIT = 0;

    // Exception codes carried towards the CSR unit in WB
    typedef enum logic [5:0] {
        ECODE_INT  = 6'h00,
        ECODE_ADEF = 6'h08,
        ECODE_ALE  = 6'h09,
        ECODE_SYS  = 6'h0b,
        ECODE_BRK  = 6'h0c,
        ECODE_INE  = 6'h0d
    } ecode_e;

    // EX -> MS payload; declaration order fixes the field offsets
    typedef struct packed {
        logic [31:0]         pc;          // [163:132]
        logic [MEM_OP_W-1:0] mem_op;      // [131:127]
        logic                res_from_mem;// [126]
        logic                mem_req;     // [125]
        logic                csr_re;      // [124]
        logic                rf_we;       // [123]
        logic [4:0]          rf_waddr;    // [122:118]
        logic [31:0]         alu_result;  // [117:86]
        logic [13:0]         csr_num;     // [85:72]
        logic [31:0]         csr_wmask;   // [71:40]
        logic [31:0]         csr_wvalue;  // [39:8]
        logic                csr_we;      // [7]
        logic                ex_int;      // [6]
        logic                ex_brk;      // [5]
        logic                ex_ine;      // [4]
        logic                ex_adef;     // [3]
        logic                ex_sys;      // [2]
        logic                ertn;        // [1]
        logic                ex_ale;      // [0]
    } es2ms_t;

    // MS -> WS payload
    typedef struct packed {
        logic [31:0] pc;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        csr_we;
        logic        ex_int;
        logic        ex_brk;
        logic        ex_ine;
        logic        ex_adef;
        logic        ex_sys;
        logic        ertn;
        logic        ex_ale;
    } ms2ws_t;

    // Any real exception (ertn is not an exception and does not kill rf_we)
    function automatic logic has_ex(input es2ms_t f);
        return f.ex_int | f.ex_brk | f.ex_ine | f.ex_adef | f.ex_sys | f.ex_ale;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
//   Purely combinational load-data extraction: picks the addressed byte or
//   halfword out of the 32-bit SRAM word and sign/zero extends it.
//   Ports:
//     mem_op  in  5   one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu}
//     addr    in  2   low address bits of the access
//     rdata   in  32  raw word from the data SRAM (or response buffer)
//     result  out 32  extended load value (raw word for ld_w / no load)
// -----------------------------------------------------------------------------
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [1:0]          addr,
    input  logic [31:0]         rdata,
    output logic [31:0]         result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    // Halfwords are naturally aligned, so only addr[1] selects
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = rdata;
        if (mem_op[LD_B_BIT])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op[LD_BU_BIT])
            result = {24'b0, byte_sel};
        else if (mem_op[LD_H_BIT])
            result = {{16{half_sel[15]}}, half_sel};
        else if (mem_op[LD_HU_BIT])
            result = {16'b0, half_sel};
        else if (mem_op[LD_W_BIT])
            result = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage between EX and WB. Holds one instruction, waits for
//   the data-SRAM response of a load/store issued in EX, extracts load data,
//   forwards the register-write triple to ID and passes CSR/exception info to
//   WB. A response still in flight when WB flushes is discarded via `cancel`.
//   Ports:
//     clk, resetn          clock, synchronous active-low reset
//     es2ms_valid/_bus     instruction from EX
//     ms_allowin           MS can accept from EX this cycle
//     data_sram_data_ok    response strobe for the oldest outstanding request
//     data_sram_rdata      response data
//     ws_allowin           WB can accept
//     ms2ws_valid/_bus     instruction to WB
//     ms_rf_zip            {csr_re, rf_we, rf_waddr, rf_wdata} for ID bypass
//     ms_ld_pending        valid load still waiting for data
//     ms_ex                MS holds an exception or ertn (block stores in EX)
//     wb_ex, ertn_flush    pipeline flush requests from WB
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,

    input  logic                es2ms_valid,
    output logic                ms_allowin,
    input  logic [ES2MS_W-1:0]  es2ms_bus,

    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,

    input  logic                ws_allowin,
    output logic                ms2ws_valid,
    output logic [MS2WS_W-1:0]  ms2ws_bus,

    output logic [RF_ZIP_W-1:0] ms_rf_zip,
    output logic                ms_ld_pending,
    output logic                ms_ex,

    input  logic                wb_ex,
    input  logic                ertn_flush
);

    es2ms_t      es_in;
    es2ms_t      ms_r;
    ms2ws_t      ws_out;

    logic        ms_valid;
    logic        cancel;
    logic        buf_valid;
    logic [31:0] rdata_buf;

    logic        flush;
    logic        data_ok_hit;
    logic        ms_ready_go;
    logic        ms_leave;
    logic        any_ex;
    logic [31:0] load_raw;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign es_in = es2ms_bus;
    assign flush = wb_ex | ertn_flush;

    // A response arriving while cancel is set belongs to a flushed
    // instruction and must not complete the current one.
    assign data_ok_hit = data_sram_data_ok & ~cancel;

    assign ms_ready_go = ~ms_r.mem_req | buf_valid | data_ok_hit;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid & ms_ready_go & ~flush;
    assign ms_leave    = ms_valid & ms_ready_go & ws_allowin;

    // ---------------------------------------------------------------- valid
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn)
            ms_valid <= 1'b0;
        else if (flush)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= es2ms_valid;
    end

    // -------------------------------------------------------------- payload
    always_ff @(posedge clk) begin
        // NOTE: the payload is a plain register (not a RAM), so it is reset to keep all outputs at 0 out of reset.
        if (!resetn)
            ms_r <= '0;
        else if (es2ms_valid && ms_allowin)
            ms_r <= es_in;
    end

    // ------------------------------------------------------ response buffer
    // Holds a response that arrived while WB was stalled, so the instruction
    // can leave later without a second data_ok.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            rdata_buf <= '0;
        end else if (flush || ms_leave) begin
            buf_valid <= 1'b0;
        end else if (ms_valid && ms_r.mem_req && data_ok_hit && !buf_valid) begin
            // Not leaving while ready implies ws_allowin is low here
            buf_valid <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    // ---------------------------------------------------------- cancel flag
    // Set when a flush kills an instruction whose request is still
    // outstanding; the next data_ok is then swallowed and clears it. A
    // response landing in the flush cycle itself needs no cancel.
    always_ff @(posedge clk) begin
        if (!resetn)
            cancel <= 1'b0;
        else if (flush && ms_valid && ms_r.mem_req && !buf_valid && !data_ok_hit)
            cancel <= 1'b1;
        else if (data_sram_data_ok)
            cancel <= 1'b0;
    end

    // ------------------------------------------------------------ load data
    assign load_raw = buf_valid ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .mem_op (ms_r.mem_op),
        .addr   (ms_r.alu_result[1:0]),
        .rdata  (load_raw),
        .result (load_data)
    );

    assign rf_wdata = ms_r.res_from_mem ? load_data : ms_r.alu_result;
    assign any_ex   = has_ex(ms_r);

    // -------------------------------------------------------------- outputs
    assign ms_rf_zip = {ms_r.csr_re & ms_valid,
                        ms_r.rf_we  & ms_valid & ~any_ex,
                        ms_r.rf_waddr,
                        rf_wdata};

    assign ms_ld_pending = ms_valid & ms_r.res_from_mem & ~ms_ready_go;
    assign ms_ex         = ms_valid & (any_ex | ms_r.ertn);

    always_comb begin
        ws_out            = '0;
        ws_out.pc         = ms_r.pc;
        ws_out.csr_num    = ms_r.csr_num;
        ws_out.csr_wmask  = ms_r.csr_wmask;
        ws_out.csr_wvalue = ms_r.csr_wvalue;
        ws_out.csr_we     = ms_r.csr_we;
        ws_out.ex_int     = ms_r.ex_int;
        ws_out.ex_brk     = ms_r.ex_brk;
        ws_out.ex_ine     = ms_r.ex_ine;
        ws_out.ex_adef    = ms_r.ex_adef;
        ws_out.ex_sys     = ms_r.ex_sys;
        ws_out.ertn       = ms_r.ertn;
        ws_out.ex_ale     = ms_r.ex_ale;
    end

    assign ms2ws_bus = ws_out;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage: directed load-extract vectors, hand
//   sequences for waiting/buffering/cancel/reset, and a randomized stream
//   checked against an in-order occupancy model.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam logic [4:0] MOP_B  = 5'b10000;
    localparam logic [4:0] MOP_H  = 5'b01000;
    localparam logic [4:0] MOP_W  = 5'b00100;
    localparam logic [4:0] MOP_BU = 5'b00010;
    localparam logic [4:0] MOP_HU = 5'b00001;
    localparam int         N_RND  = 150;

    logic         clk = 1'b0;
    logic         resetn;
    logic         es2ms_valid;
    logic         ms_allowin;
    logic [163:0] es2ms_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [117:0] ms2ws_bus;
    logic [38:0]  ms_rf_zip;
    logic         ms_ld_pending;
    logic         ms_ex;
    logic         wb_ex;
    logic         ertn_flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es2ms_valid       (es2ms_valid),
        .ms_allowin        (ms_allowin),
        .es2ms_bus         (es2ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms2ws_valid       (ms2ws_valid),
        .ms2ws_bus         (ms2ws_bus),
        .ms_rf_zip         (ms_rf_zip),
        .ms_ld_pending     (ms_ld_pending),
        .ms_ex             (ms_ex),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush)
    );

    // ------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [163:0] act, input logic [163:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, 164'(act), 164'(exp));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, 164'(act), 164'(exp));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic send(input logic [163:0] b);
        es2ms_valid = 1'b1;
        es2ms_bus   = b;
        tick;
        es2ms_valid = 1'b0;
    endtask

    // exf = {ex_int, ex_brk, ex_ine, ex_adef, ex_sys, ertn, ex_ale}
    function automatic logic [163:0] make_es(
        input logic [31:0] pc, input logic [4:0] mop, input logic res, input logic req,
        input logic csr_re, input logic rf_we, input logic [4:0] waddr, input logic [31:0] alu,
        input logic [13:0] csr_num, input logic [31:0] wmask, input logic [31:0] wvalue,
        input logic csr_we, input logic [6:0] exf);
        return {pc, mop, res, req, csr_re, rf_we, waddr, alu, csr_num, wmask, wvalue, csr_we, exf};
    endfunction

    function automatic logic [117:0] make_ws(
        input logic [31:0] pc, input logic [13:0] csr_num, input logic [31:0] wmask,
        input logic [31:0] wvalue, input logic csr_we, input logic [6:0] exf);
        return {pc, csr_num, wmask, wvalue, csr_we, exf};
    endfunction

    function automatic logic [163:0] ldw(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu);
        return make_es(pc, MOP_W, 1'b1, 1'b1, 1'b0, 1'b1, rd, alu, 14'd0, 32'd0, 32'd0, 1'b0, 7'd0);
    endfunction

    // Reference load extraction from the byte/halfword rules, in arithmetic
    function automatic logic [31:0] ref_load(input logic [4:0] mop, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'hff;
        h = (d >> (16 * a[1])) & 32'hffff;
        case (mop)
            MOP_B:   return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            MOP_BU:  return b;
            MOP_H:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            MOP_HU:  return h;
            default: return d;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        chk1({tag, " ms_allowin"}, ms_allowin, 1'b1);
        chk1({tag, " ms2ws_valid"}, ms2ws_valid, 1'b0);
        chk1({tag, " ms_ld_pending"}, ms_ld_pending, 1'b0);
        chk1({tag, " ms_ex"}, ms_ex, 1'b0);
        check({tag, " ms_rf_zip"}, 164'(ms_rf_zip), 164'd0);
        check({tag, " ms2ws_bus"}, 164'(ms2ws_bus), 164'd0);
    endtask

    // ------------------------------------------------------ vector table
    typedef struct {
        string       name;
        logic [4:0]  mop;
        logic        res;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vec[10];

    // ------------------------------------------------------ random model
    typedef struct {
        logic [163:0] bus;
        logic         req;
        logic         res;
        int           delay;
        logic [31:0]  rdata;
        logic [38:0]  zip;
        logic [117:0] ws;
    } rinst_t;

    function automatic rinst_t gen_inst(input int id);
        rinst_t      r;
        int          k;
        logic [4:0]  mop;
        logic        res;
        logic        req;
        logic [6:0]  exf;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [13:0] cnum;
        logic [31:0] wm;
        logic [31:0] wv;
        logic        cwe;
        k      = $urandom_range(0, 7);
        alu    = $urandom();
        pc     = 32'h1c00_0000 + 32'(id * 4);
        csr_re = 1'($urandom_range(0, 1));
        rf_we  = 1'($urandom_range(0, 1));
        waddr  = 5'($urandom_range(0, 31));
        cnum   = 14'($urandom());
        wm     = $urandom();
        wv     = $urandom();
        cwe    = 1'($urandom_range(0, 1));
        exf    = 7'd0;
        mop    = 5'd0;
        res    = 1'b0;
        req    = 1'b0;
        case (k)
            2: begin mop = MOP_B;  res = 1'b1; req = 1'b1; end
            3: begin mop = MOP_H;  res = 1'b1; req = 1'b1; alu[0] = 1'b0; end
            4: begin mop = MOP_W;  res = 1'b1; req = 1'b1; alu[1:0] = 2'b00; end
            5: begin mop = MOP_BU; res = 1'b1; req = 1'b1; end
            6: begin mop = MOP_HU; res = 1'b1; req = 1'b1; alu[0] = 1'b0; end
            7: begin
                if ($urandom_range(0, 1) == 0) req = 1'b1;          // store
                else exf = 7'(1 << $urandom_range(0, 6));          // exception or ertn, no request
            end
            default: ;                                             // ALU op
        endcase
        r.bus   = make_es(pc, mop, res, req, csr_re, rf_we, waddr, alu, cnum, wm, wv, cwe, exf);
        r.req   = req;
        r.res   = res;
        r.delay = $urandom_range(0, 3);
        r.rdata = $urandom();
        r.zip   = {csr_re, rf_we & ~(|(exf & 7'b1111101)), waddr,
                   res ? ref_load(mop, alu[1:0], r.rdata) : alu};
        r.ws    = make_ws(pc, cnum, wm, wv, cwe, exf);
        return r;
    endfunction

    rinst_t cur;
    logic   have_cur;
    rinst_t occ[$];
    logic   resp_pend;
    int     resp_wait;
    logic   got_resp;
    int     issued;
    int     retired;
    logic   exp_go;
    logic   exp_allow;
    logic   drained;

    // ---------------------------------------------------------- watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // -------------------------------------------------------------- test
    initial begin
        vec[0] = '{"ld_b a3",  MOP_B,  1'b1, 32'h1000_0003, 32'h8012_3456, 32'hFFFF_FF80};
        vec[1] = '{"ld_bu a3", MOP_BU, 1'b1, 32'h1000_0003, 32'h8012_3456, 32'h0000_0080};
        vec[2] = '{"ld_hu a2", MOP_HU, 1'b1, 32'h1000_0002, 32'hBEEF_0000, 32'h0000_BEEF};
        vec[3] = '{"ld_h a2",  MOP_H,  1'b1, 32'h1000_0002, 32'h8001_5555, 32'hFFFF_8001};
        vec[4] = '{"ld_h a0",  MOP_H,  1'b1, 32'h1000_0000, 32'h1234_7FFF, 32'h0000_7FFF};
        vec[5] = '{"ld_b a1",  MOP_B,  1'b1, 32'h1000_0001, 32'h0000_F100, 32'hFFFF_FFF1};
        vec[6] = '{"ld_bu a1", MOP_BU, 1'b1, 32'h1000_0001, 32'h0000_AB00, 32'h0000_00AB};
        vec[7] = '{"ld_w a0",  MOP_W,  1'b1, 32'h1000_0000, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vec[8] = '{"alu",      5'd0,   1'b0, 32'h1122_3344, 32'hDEAD_BEEF, 32'h1122_3344};
        vec[9] = '{"ld_b a2",  MOP_B,  1'b1, 32'h1000_0002, 32'h00FE_0000, 32'hFFFF_FFFE};

        resetn            = 1'b0;
        es2ms_valid       = 1'b0;
        es2ms_bus         = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        wb_ex             = 1'b0;
        ertn_flush        = 1'b0;

        // Reset state
        repeat (3) tick;
        check_idle("reset");
        resetn = 1'b1;
        tick;

        // Table-driven single-cycle loads and ALU pass
        for (int i = 0; i < 10; i++) begin
            send(make_es(32'h1c00_0100 + 32'(i * 4), vec[i].mop, vec[i].res, vec[i].mop != 5'd0,
                         1'b0, 1'b1, 5'(i + 1), vec[i].alu, 14'd0, 32'd0, 32'd0, 1'b0, 7'd0));
            data_sram_data_ok = (vec[i].mop != 5'd0);
            data_sram_rdata   = vec[i].rdata;
            settle;
            chk1({vec[i].name, " ms2ws_valid"}, ms2ws_valid, 1'b1);
            check({vec[i].name, " rf_zip"}, 164'(ms_rf_zip), 164'({1'b0, 1'b1, 5'(i + 1), vec[i].exp}));
            tick;
            data_sram_data_ok = 1'b0;
        end

        // ld_w answered 3 cycles after entry
        send(ldw(32'h1c00_0200, 5'd3, 32'h0000_0040));
        for (int k = 0; k < 3; k++) begin
            settle;
            chk1($sformatf("wait%0d ms_ld_pending", k), ms_ld_pending, 1'b1);
            chk1($sformatf("wait%0d ms2ws_valid", k), ms2ws_valid, 1'b0);
            tick;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8765_4321;
        settle;
        chk1("wait done ms2ws_valid", ms2ws_valid, 1'b1);
        chk1("wait done ms_ld_pending", ms_ld_pending, 1'b0);
        chk32("wait done wdata", ms_rf_zip[31:0], 32'h8765_4321);
        tick;
        data_sram_data_ok = 1'b0;
        settle;
        chk1("wait left ms2ws_valid", ms2ws_valid, 1'b0);

        // Response buffered while WB stalls
        send(ldw(32'h1c00_0300, 5'd4, 32'h0000_0080));
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1234;
        settle;
        chk1("buf ms2ws_valid", ms2ws_valid, 1'b1);
        chk1("buf ms_allowin", ms_allowin, 1'b0);
        tick;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            settle;
            chk1($sformatf("buf hold%0d ms2ws_valid", k), ms2ws_valid, 1'b1);
            chk32($sformatf("buf hold%0d wdata", k), ms_rf_zip[31:0], 32'h0000_1234);
            tick;
        end
        ws_allowin = 1'b1;
        settle;
        chk1("buf release ms2ws_valid", ms2ws_valid, 1'b1);
        chk1("buf release ms_allowin", ms_allowin, 1'b1);
        chk32("buf release wdata", ms_rf_zip[31:0], 32'h0000_1234);
        tick;
        settle;
        chk1("buf left ms2ws_valid", ms2ws_valid, 1'b0);

        // Flush while waiting: stale response is dropped
        send(ldw(32'h1c00_0400, 5'd5, 32'h0000_0100));
        settle;
        chk1("cancel pre ms_ld_pending", ms_ld_pending, 1'b1);
        tick;
        wb_ex = 1'b1;
        settle;
        chk1("cancel flush ms2ws_valid", ms2ws_valid, 1'b0);
        tick;
        wb_ex       = 1'b0;
        es2ms_valid = 1'b1;
        es2ms_bus   = ldw(32'h1c00_0404, 5'd6, 32'h0000_0104);
        settle;
        chk1("cancel after ms_allowin", ms_allowin, 1'b1);
        chk1("cancel after ms_ld_pending", ms_ld_pending, 1'b0);
        tick;
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        settle;
        chk1("cancel stale ms2ws_valid", ms2ws_valid, 1'b0);
        chk1("cancel stale ms_ld_pending", ms_ld_pending, 1'b1);
        tick;
        data_sram_rdata = 32'h0000_BEEF;
        settle;
        chk1("cancel new ms2ws_valid", ms2ws_valid, 1'b1);
        chk32("cancel new wdata", ms_rf_zip[31:0], 32'h0000_BEEF);
        tick;
        data_sram_data_ok = 1'b0;

        // Flush in the same cycle as data_ok leaves no cancel behind
        send(ldw(32'h1c00_0500, 5'd7, 32'h0000_0200));
        ertn_flush        = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_5555;
        settle;
        chk1("flush+ok ms2ws_valid", ms2ws_valid, 1'b0);
        tick;
        ertn_flush        = 1'b0;
        data_sram_data_ok = 1'b0;
        send(ldw(32'h1c00_0504, 5'd8, 32'h0000_0204));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h00C0_FFEE;
        settle;
        chk1("flush+ok next ms2ws_valid", ms2ws_valid, 1'b1);
        chk32("flush+ok next wdata", ms_rf_zip[31:0], 32'h00C0_FFEE);
        tick;
        data_sram_data_ok = 1'b0;

        // Exception instruction passes in one cycle without writing the RF
        send(make_es(32'h1c00_0600, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0042,
                     14'h0005, 32'h0000_00FF, 32'h0000_0011, 1'b1, 7'b0000100));
        settle;
        chk1("sys ms_ex", ms_ex, 1'b1);
        chk1("sys rf_we", ms_rf_zip[37], 1'b0);
        chk1("sys ms2ws_valid", ms2ws_valid, 1'b1);
        chk1("sys bus ex_sys", ms2ws_bus[2], 1'b1);
        check("sys ms2ws_bus", 164'(ms2ws_bus),
              164'(make_ws(32'h1c00_0600, 14'h0005, 32'h0000_00FF, 32'h0000_0011, 1'b1, 7'b0000100)));
        tick;
        settle;
        chk1("sys left ms_ex", ms_ex, 1'b0);

        // Reset while a load waits with cancel set
        send(ldw(32'h1c00_0700, 5'd10, 32'h0000_0300));
        wb_ex = 1'b1;
        tick;
        wb_ex = 1'b0;
        send(ldw(32'h1c00_0704, 5'd11, 32'h0000_0304));
        resetn = 1'b0;
        tick;
        settle;
        check_idle("mid reset");
        resetn = 1'b1;
        send(ldw(32'h1c00_0708, 5'd12, 32'h0000_0308));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_F00D;
        settle;
        chk1("post reset ms2ws_valid", ms2ws_valid, 1'b1);
        chk32("post reset wdata", ms_rf_zip[31:0], 32'h0BAD_F00D);
        tick;
        data_sram_data_ok = 1'b0;
        tick;

        // Randomized stream against the occupancy model
        have_cur  = 1'b0;
        resp_pend = 1'b0;
        resp_wait = 0;
        got_resp  = 1'b0;
        issued    = 0;
        retired   = 0;
        drained   = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (issued == N_RND && occ.size() == 0) begin
                drained = 1'b1;
                break;
            end
            if (!have_cur && issued < N_RND) begin
                cur      = gen_inst(issued);
                have_cur = 1'b1;
            end
            es2ms_valid       = have_cur && ($urandom_range(0, 3) != 0);
            es2ms_bus         = have_cur ? cur.bus : es2ms_bus;
            ws_allowin        = ($urandom_range(0, 3) != 0);
            data_sram_data_ok = resp_pend && (resp_wait == 0);
            data_sram_rdata   = data_sram_data_ok ? occ[0].rdata : $urandom();
            settle;

            exp_go    = (occ.size() > 0) && (!occ[0].req || got_resp || data_sram_data_ok);
            exp_allow = (occ.size() == 0) || (exp_go && ws_allowin);
            chk1("rnd ms2ws_valid", ms2ws_valid, exp_go);
            chk1("rnd ms_allowin", ms_allowin, exp_allow);
            chk1("rnd ms_ld_pending", ms_ld_pending, (occ.size() > 0) && occ[0].res && !exp_go);
            if (exp_go && ws_allowin) begin
                check($sformatf("rnd#%0d rf_zip", retired), 164'(ms_rf_zip), 164'(occ[0].zip));
                check($sformatf("rnd#%0d ms2ws_bus", retired), 164'(ms2ws_bus), 164'(occ[0].ws));
            end

            if (data_sram_data_ok) begin
                resp_pend = 1'b0;
                got_resp  = 1'b1;
            end else if (resp_pend) begin
                resp_wait--;
            end
            if (exp_go && ws_allowin) begin
                void'(occ.pop_front());
                retired++;
                got_resp = 1'b0;
            end
            if (es2ms_valid && exp_allow) begin
                occ.push_back(cur);
                have_cur = 1'b0;
                issued++;
                got_resp = 1'b0;
                if (cur.req) begin
                    resp_pend = 1'b1;
                    resp_wait = cur.delay;
                end
            end
            tick;
        end
        es2ms_valid       = 1'b0;
        data_sram_data_ok = 1'b0;
        chk1("rnd stream drained", drained, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
